// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative shift-add multiply and restoring divide.
// Define ALU_SEQ_SIGNED_MULDIV_EN to make opcodes 1100/1110 signed; otherwise they run unsigned.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // done pulses for one cycle with result/hi/flags valid, and they hold until the next completion.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

  state_t           state, state_next;
  logic             accept, op_mul, op_div;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work_hi, work_lo, mop;
  logic             dbz_q;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_zero_ok;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   msum, shifted;
  logic [WIDTH-1:0] dsub;
  logic             dge;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

  assign op_mul    = (ALUControl[3:2] == 2'b11) && !ALUControl[1];
  assign op_div    = (ALUControl[3:2] == 2'b11) &&  ALUControl[1];
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == MUL) || (state == DIV);
  assign done      = (state == DONE);
  assign state_dbg = state;
  assign shamt     = srcB[SHW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (op_mul)      state_next = MUL;
          else if (op_div) state_next = DIV;
          else             state_next = DONE;
        end else begin
          state_next = IDLE;
        end
      end
      MUL, DIV: if (cnt == '0) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    sum         = srcA + srcB;
    diff        = srcA - srcB;
    alu_res     = '0;
    alu_ovf     = 1'b0;
    alu_zero_ok = 1'b1;
    case (ALUControl)
      4'b0000: begin
        alu_res = sum;
        alu_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
      end
      4'b0010: alu_res = srcA & srcB;
      4'b0011: alu_res = srcA | srcB;
      4'b0100: alu_res = srcA ^ srcB;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'b0110: alu_res = ~(srcA | srcB);
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      4'b1000: alu_res = srcA << shamt;
      4'b1001: alu_res = srcA >> shamt;
      4'b1010: alu_res = $unsigned($signed(srcA) >>> shamt);
      default: alu_zero_ok = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_SIGNED_MULDIV_EN
  logic             sgn_sel, a_neg, b_neg;
  logic             neg_lo_q, neg_hi_q;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    sgn_sel = (ALUControl[3:2] == 2'b11) && !ALUControl[0];
    a_neg   = sgn_sel && srcA[WIDTH-1];
    b_neg   = sgn_sel && srcB[WIDTH-1];
    a_mag   = a_neg ? -srcA : srcA;
    b_mag   = b_neg ? -srcB : srcB;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
    end
  end
`else
  assign a_mag = srcA;
  assign b_mag = srcB;
`endif

  // One iteration per busy cycle; work_hi/work_lo double as product halves or remainder/quotient.
  always_comb begin
    msum    = {1'b0, work_hi} + {1'b0, (work_lo[0] ? mop : '0)};
    shifted = {work_hi, work_lo[WIDTH-1]};
    dge     = shifted >= {1'b0, mop};
    dsub    = shifted[WIDTH-1:0] - mop;
    if (state == MUL) begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], work_lo[WIDTH-1:1]};
    end else begin
      step_hi = dge ? dsub : shifted[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], dge};
    end
  end

  always_comb begin
    fin_hi = step_hi;
    fin_lo = step_lo;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    prod_neg = -{step_hi, step_lo};
    if (state == MUL) begin
      if (neg_lo_q) {fin_hi, fin_lo} = prod_neg;
    end else begin
      if (neg_lo_q) fin_lo = -step_lo;
      if (neg_hi_q) fin_hi = -step_hi;
    end
`endif
    // Divide by zero reports all ones regardless of operand signs.
    if ((state == DIV) && dbz_q) fin_lo = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      mop         <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (op_mul || op_div) begin
        cnt     <= CNT_MAX;
        work_hi <= '0;
        work_lo <= op_mul ? b_mag : a_mag;
        mop     <= op_mul ? a_mag : b_mag;
        dbz_q   <= op_div && (srcB == '0);
      end else begin
        result      <= alu_res;
        hi          <= '0;
        zero        <= alu_zero_ok && (alu_res == '0);
        overflow    <= alu_ovf;
        div_by_zero <= 1'b0;
      end
    end else if (busy) begin
      cnt     <= cnt - SHW'(1);
      work_hi <= step_hi;
      work_lo <= step_lo;
      if (cnt == '0) begin
        result      <= fin_lo;
        hi          <= fin_hi;
        zero        <= (fin_lo == '0);
        overflow    <= 1'b0;
        div_by_zero <= (state == DIV) && dbz_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against a wide-arithmetic model.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic [3:0]   ALUControl = '0;
  logic [W-1:0] result, hi;
  logic         zero, overflow, div_by_zero, busy, done;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi_q[$];
  logic [2:0]   exp_fl_q[$];

  logic [3:0]   p_op[$];
  logic [W-1:0] p_a[$];
  logic [W-1:0] p_b[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .srcA(srcA), .srcB(srcB),
    .ALUControl(ALUControl), .result(result), .hi(hi), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: plain 64-bit arithmetic straight from the opcode definitions.
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [W-1:0] h, output logic [2:0] fl);
    longint sa, sb, s;
    logic [63:0] p;
    logic sgn, z, ov, dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; ov = 1'b0; dz = 1'b0;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    sgn = (op == 4'b1100) || (op == 4'b1110);
`else
    sgn = 1'b0;
`endif
    case (op)
      4'd0:  begin s = sa + sb; r = W'(s); ov = (s != longint'($signed(r))); end
      4'd1:  begin s = sa - sb; r = W'(s); ov = (s != longint'($signed(r))); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 1 : 0;
      4'd6:  r = ~(a | b);
      4'd7:  r = (a < b) ? 1 : 0;
      4'd8:  r = a << b[4:0];
      4'd9:  r = a >> b[4:0];
      4'd10: r = W'(sa >>> b[4:0]);
      4'd12, 4'd13: begin
        if (sgn) p = 64'(sa * sb);
        else     p = {32'b0, a} * {32'b0, b};
        {h, r} = p;
      end
      4'd14, 4'd15: begin
        if (b == '0) begin
          r = '1; h = a; dz = 1'b1;
        end else if (sgn) begin
          r = W'(sa / sb); h = W'(sa % sb);
        end else begin
          r = a / b; h = a % b;
        end
      end
      default: r = '0;
    endcase
    z = (op != 4'd11) && (r == '0);
    fl = {z, ov, dz};
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // Driver: issue one op, wait for done (bounded), check latency, busy length and outputs.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [W-1:0] er, eh;
    logic [2:0] ef;
    int cyc, busy_n, exp_lat;
    ref_model(op, a, b, er, eh, ef);
    exp_q.push_back(er); exp_hi_q.push_back(eh); exp_fl_q.push_back(ef);
    exp_lat = (op[3:2] == 2'b11) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; srcA = a; srcB = b; ALUControl = op;
    cyc = 0; busy_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done || !poke) start = 1'b0;
      else start = 1'($urandom_range(0, 1));
      srcA = $urandom; srcB = $urandom; ALUControl = 4'($urandom_range(0, 15));
    end while (!done && cyc < 200);
    start = 1'b0;
    check($sformatf("op%0d latency", op), W'(cyc), W'(exp_lat));
    check($sformatf("op%0d busy_cycles", op), W'(busy_n), W'(exp_lat - 1));
    check($sformatf("op%0d result", op), result, exp_q.pop_front());
    check($sformatf("op%0d hi", op), hi, exp_hi_q.pop_front());
    check($sformatf("op%0d flags", op), W'({zero, overflow, div_by_zero}), W'(exp_fl_q.pop_front()));
  endtask

  // Driver: back-to-back single-cycle ops, each new start issued in the previous done cycle.
  task automatic pipe_run();
    logic [W-1:0] er, eh;
    logic [2:0] ef;
    int n;
    n = p_op.size();
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ref_model(p_op[i], p_a[i], p_b[i], er, eh, ef);
      exp_q.push_back(er); exp_hi_q.push_back(eh); exp_fl_q.push_back(ef);
      start = 1'b1; srcA = p_a[i]; srcB = p_b[i]; ALUControl = p_op[i];
      @(negedge clk);
      check($sformatf("pipe%0d done", i), W'(done), W'(1));
      check($sformatf("pipe%0d result", i), result, exp_q.pop_front());
      check($sformatf("pipe%0d hi", i), hi, exp_hi_q.pop_front());
      check($sformatf("pipe%0d flags", i), W'({zero, overflow, div_by_zero}), W'(exp_fl_q.pop_front()));
    end
    start = 1'b0;
    p_op.delete(); p_a.delete(); p_b.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst result", result, '0);
    check("rst hi", hi, '0);
    check("rst flags", W'({zero, overflow, div_by_zero}), '0);
    check("rst busy_done", W'({busy, done}), '0);
    reset_n = 1'b1;

    run_op(4'b0000, 32'h7fff_ffff, 32'd1, 1'b0);
    check("tp add result", result, 32'h8000_0000);
    check("tp add overflow", W'(overflow), W'(1));

    p_op = {4'b0001, 4'b0101, 4'b0111};
    p_a  = {32'd5, 32'hffff_ffff, 32'hffff_ffff};
    p_b  = {32'd5, 32'd1, 32'd1};
    pipe_run();

    run_op(4'b1100, 32'hffff_fffd, 32'd7, 1'b0);
    run_op(4'b1111, 32'd100, 32'd7, 1'b0);
    check("tp divu quotient", result, 32'd14);
    check("tp divu remainder", hi, 32'd2);
    run_op(4'b1111, 32'd100, 32'd0, 1'b0);
    check("tp divu0 hi", hi, 32'd100);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; srcA = 32'hffff_fffd; srcB = 32'd7; ALUControl = 4'b1100;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst busy before", W'(busy), W'(1));
    reset_n = 1'b0;
    #1;
    check("midrst result", result, '0);
    check("midrst hi", hi, '0);
    check("midrst flags", W'({zero, overflow, div_by_zero}), '0);
    check("midrst busy_done", W'({busy, done}), '0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(4'b0010, 32'hf0f0_1234, 32'h0ff0_ff00, 1'b0);

    // start pulses with fresh operands while busy must be ignored
    run_op(4'b1101, 32'h1234_5678, 32'h9abc_def0, 1'b1);
    run_op(4'b1110, 32'h8000_0000, 32'hffff_ffff, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 30; i++) begin
      p_op.push_back(4'($urandom_range(0, 11)));
      p_a.push_back(pick_operand());
      p_b.push_back(pick_operand());
    end
    pipe_run();

    @(negedge clk);
    check("idle after pipe", W'({busy, done}), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
